// File: rtl/dlyd_meas_pkg.sv
// Shared types and helpers for the dlyd chain measurement controller.
// Holds the FSM state enum, the result width helper and the thermometer decoder.
package dlyd_meas_pkg;

    localparam int MAX_TAPS = 256;
    localparam int COUNT_W  = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SYNC,
        ST_DECODE,
        ST_RECOVER,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic               bubble;
        logic               ovf;
    } therm_t;

    function automatic int cw_of(input int ntaps);
        return $clog2(ntaps + 1);
    endfunction

    // Counts contiguous ones from bit 0; any one above the first zero is a bubble.
    function automatic therm_t thermo_count(input logic [MAX_TAPS-1:0] vec, input int n);
        therm_t r;
        logic   seen_zero;
        r         = '0;
        seen_zero = 1'b0;
        for (int i = 0; i < MAX_TAPS; i++) begin
            if (i < n) begin
                if (!vec[i])
                    seen_zero = 1'b1;
                else if (seen_zero)
                    r.bubble = 1'b1;
                else
                    r.count = r.count + COUNT_W'(1);
            end
        end
        r.ovf = !seen_zero;
        return r;
    endfunction

endpackage

// File: rtl/dlyd_chain_meas_if.sv
// Host-side signal bundle of the dlyd chain measurement controller.
// The controller uses the slave modport; the chain model or host uses master.
interface dlyd_chain_meas_if import dlyd_meas_pkg::*; #(
    parameter int NTAPS = 32
) ();
    localparam int CW = cw_of(NTAPS);

    logic             start;
    logic [NTAPS-1:0] taps;
    logic             launch;
    logic             busy;
    logic             done;
    logic             valid;
    logic [CW-1:0]    result;
    logic             err;

    modport master (
        output start, taps,
        input  launch, busy, done, valid, result, err
    );

    modport slave (
        input  start, taps,
        output launch, busy, done, valid, result, err
    );
endinterface

// File: rtl/dlyd_meas_decode.sv
// Combinational tap decoder: count of contiguous ones plus bubble/overflow flags.
// DLYD_MEAS_BUBBLE_FIX_EN enables a 3-tap majority filter on interior taps first.
module dlyd_meas_decode import dlyd_meas_pkg::*; #(
    parameter int NTAPS = 32,
    parameter int CW    = cw_of(NTAPS)
) (
    input  logic [NTAPS-1:0] cap_s,
    output logic [CW-1:0]    count,
    output logic             bubble,
    output logic             ovf
);

    logic [NTAPS-1:0] filt;
    therm_t           res;

`ifdef DLYD_MEAS_BUBBLE_FIX_EN
    always_comb begin
        filt = cap_s;
        for (int i = 1; i < NTAPS - 1; i++)
            filt[i] = (cap_s[i-1] & cap_s[i]) | (cap_s[i] & cap_s[i+1]) |
                      (cap_s[i-1] & cap_s[i+1]);
    end
`else
    always_comb begin
        filt = cap_s;
    end
`endif

    always_comb begin
        res = thermo_count(MAX_TAPS'(filt), NTAPS);
    end

    assign count  = CW'(res.count);
    assign bubble = res.bubble;
    assign ovf    = res.ovf;

endmodule

// File: rtl/dlyd_chain_meas.sv
// Launches an edge into the dlyd chain, samples the taps one period later and
// averages 2^NSAMP_LOG2 tap counts into a taps-per-period result.
//
// state   | meaning
// IDLE    | waiting for start
// LAUNCH  | launch high, taps captured into cap_q on exit
// SYNC    | cap_q settles into cap_s
// DECODE  | tap count accumulated, launch dropped, recovery timer loaded
// RECOVER | chain drains with launch low for RECOVER_CYC cycles
// DONE    | result/valid updated, done pulse
module dlyd_chain_meas import dlyd_meas_pkg::*; #(
    parameter int NTAPS       = 32,
    parameter int NSAMP_LOG2  = 2,
    parameter int RECOVER_CYC = 4
) (
    input  logic              CLK,
    input  logic              RN,
    dlyd_chain_meas_if.slave  bus
);

    localparam int         CW        = cw_of(NTAPS);
    localparam int         AW        = CW + NSAMP_LOG2;
    localparam logic [4:0] LAST_SAMP = 5'((1 << NSAMP_LOG2) - 1);
    localparam logic [7:0] RCV_LOAD  = 8'(RECOVER_CYC);

    state_t           state;
    logic [NTAPS-1:0] cap_q;
    logic [NTAPS-1:0] cap_s;
    logic [AW-1:0]    acc;
    logic [4:0]       scnt;
    logic [7:0]       rcnt;

    logic             launch_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic [CW-1:0]    result_q;
    logic             err_q;

    logic [CW-1:0]    count;
    logic             bubble;
    logic             ovf;

    dlyd_meas_decode #(
        .NTAPS (NTAPS),
        .CW    (CW)
    ) u_decode (
        .cap_s  (cap_s),
        .count  (count),
        .bubble (bubble),
        .ovf    (ovf)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= ST_IDLE;
            cap_q    <= '0;
            cap_s    <= '0;
            acc      <= '0;
            scnt     <= '0;
            rcnt     <= '0;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state    <= ST_LAUNCH;
                        launch_q <= 1'b1;
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b0;
                        err_q    <= 1'b0;
                        acc      <= '0;
                        scnt     <= '0;
                    end
                end
                ST_LAUNCH: begin
                    cap_q <= bus.taps;
                    state <= ST_SYNC;
                end
                ST_SYNC: begin
                    cap_s <= cap_q;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    acc      <= acc + AW'(count);
                    launch_q <= 1'b0;
                    rcnt     <= RCV_LOAD;
                    if (bubble || ovf)
                        err_q <= 1'b1;
                    state    <= ST_RECOVER;
                end
                ST_RECOVER: begin
                    if (rcnt <= 8'd1) begin
                        if (scnt < LAST_SAMP) begin
                            scnt     <= scnt + 5'd1;
                            launch_q <= 1'b1;
                            state    <= ST_LAUNCH;
                        end else begin
                            // result/done land together so done marks the updated value
                            result_q <= CW'(acc >> NSAMP_LOG2);
                            done_q   <= 1'b1;
                            valid_q  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end else begin
                        rcnt <= rcnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.launch = launch_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: doc/dlyd_chain_meas.md
Name: dlyd_chain_meas

Overview:
- Measurement controller for a chain of dlyd delay cells. It launches a rising edge into an external dlyd chain and samples the chain's tap outputs one CLK period later.
- It converts the captured thermometer code to a tap count and averages 2^NSAMP_LOG2 samples.
- It reports taps-per-clock-period, which characterises delay-cell speed for PVT tracking and delay-tap selection.
- Sits beside a hardened dlyd chain. It drives the chain input and reads the chain outputs.

Parameters:
- NTAPS, 32: number of chain taps sampled; taps[0] is the first cell output.
- NSAMP_LOG2, 2: log2 of the samples averaged per measurement (range 0..4).
- RECOVER_CYC, 4: CLK cycles launch is held low between samples so the chain drains (range 1..255).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RN  input  1  asynchronous active-low reset.
- start  input  1  measurement request; sampled in IDLE only.
- taps  input  NTAPS  chain tap outputs; asynchronous to CLK.
- launch  output  1  registered drive into the chain input.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when result is updated.
- valid  output  1  result holds a completed measurement.
- result  output  CW  averaged tap count, CW = $clog2(NTAPS+1).
- err  output  1  sticky bubble/overflow flag for the last measurement.

Behaviour:
- Reset (RN low, asynchronous): all outputs 0, state IDLE, accumulator and counters 0. Reset mid-measurement drops launch immediately and discards the measurement.
- States: IDLE, LAUNCH, SYNC, DECODE, RECOVER, DONE.
- IDLE:
  - start=1 at edge E0 moves to LAUNCH.
  - launch=1, busy=1, valid=0 and err=0 all take effect after E0.
  - accumulator and sample count clear.
  - start while busy is ignored; there is no queueing.
- LAUNCH, 1 cycle: the edge leaving it captures taps into cap_q, the first flop.
- SYNC, 1 cycle: cap_s <= cap_q, a metastability settle stage.
- DECODE, 1 cycle:
  - count = number of contiguous 1s from taps[0] in cap_s.
  - A 1 above the first 0 is a bubble: set err.
  - All NTAPS ones is overflow: count = NTAPS, set err.
  - acc += count; launch <= 0; recovery counter loads RECOVER_CYC.
- RECOVER, RECOVER_CYC cycles, launch low:
  - On expiry, if the sample count is below 2^NSAMP_LOG2 - 1, increment it and go to LAUNCH (launch=1 next cycle).
  - Otherwise go to DONE.
- DONE, 1 cycle:
  - result <= acc >> NSAMP_LOG2, truncating.
  - done=1, valid <= 1; next state IDLE with busy=0.
- Timing: each sample takes 3+RECOVER_CYC cycles. With defaults, done is high in cycle 29 after E0 (4*(3+4)+1), and busy is high for exactly 29 cycles.
- Widths: acc is CW+NSAMP_LOG2 bits and cannot overflow. result and valid hold until the next accepted start.
- launch is glitch-free: a flop output with no combinational path.

Optional Feature:
- DLYD_MEAS_BUBBLE_FIX_EN, defined: before counting, each interior tap i is replaced by majority(cap_s[i-1], cap_s[i], cap_s[i+1]). taps[0] and taps[NTAPS-1] pass unchanged. A single-bit bubble is corrected and does not set err; only overflow or a residual bubble after correction sets err.
- DLYD_MEAS_BUBBLE_FIX_EN, undefined: raw decode as above, and any bubble sets err.

Decomposition:
- Package dlyd_meas_pkg holds:
  - the state enum;
  - the CW width function (clog2);
  - the thermo_count function (contiguous-ones count plus bubble and overflow flags).
- One sub-module, dlyd_meas_decode: combinational, cap_s in; count, bubble and ovf out. The optional majority filter lives inside it. FSM, accumulator and counters stay in the top.

Test Plan:
- Reset/idle: RN low then high, no start. launch, busy, done, valid, result and err stay 0 for 50 cycles.
- Clean thermometer: the chain model gives 10 taps per period on every sample with defaults. done is high in cycle 29 after start, result=10, err=0, valid=1.
- Averaging/truncation: samples 9, 10, 10, 12. result=10 (41>>2), err=0.
- Overflow: all 32 taps high on every sample. result=32, err=1.
- Bubble: pattern 0x000003FB (bit 2 low) on one sample, others 10. Without the macro, err=1 and result=8 ((2+10+10+10)>>2). With DLYD_MEAS_BUBBLE_FIX_EN, err=0 and result=10.
- Reset mid-measurement: RN pulsed low in RECOVER of sample 2. launch drops asynchronously and all outputs clear. A new start then completes normally with result=10.
